// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Precise-exception sequencer: prioritises exceptions, commits
//               cause/EPC to coprocessor 0, then runs the flush/redirect cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_int_i,
    input  logic        sys_i,
    input  logic        unimpl_i,
    input  logic        ov_i,
    input  logic        eret_i,
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic [31:0] pc_e_i,
    input  logic [31:0] pc_m_i,
    input  logic [31:0] status_i,
    output logic        cause_epc_write_o,
    output logic [31:0] exc_code_o,
    output logic [31:0] epc_o,
    output logic        ret_op_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] handler_pc_o
);

    localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_prev;
    logic        r_int_pending;
    logic        w_int_pending_nxt;
    logic        w_int_edge;

    logic        w_en_ov;
    logic        w_en_unimpl;
    logic        w_en_sys;
    logic        w_en_int;
    logic        w_event;
    logic        w_int_acc;
    logic [1:0]  w_code;
    logic [31:0] w_pc_sel;

    logic        w_cew_nxt;
    logic [31:0] w_code_nxt;
    logic [31:0] w_epc_nxt;
    logic        w_ret_nxt;
    logic        w_flush_nxt;
    logic        w_redirect_nxt;
    logic [31:0] w_hpc_nxt;

    logic        w_unused_status;
    assign w_unused_status = &{1'b0, status_i[31:4]};

    assign w_int_edge  = r_sync2 & ~r_sync_prev;
    assign w_en_ov     = ov_i & status_i[3];
    assign w_en_unimpl = unimpl_i & status_i[2];
    assign w_en_sys    = sys_i & status_i[1];
    assign w_en_int    = r_int_pending & status_i[0];

    // Oldest instruction in the pipe wins
    always_comb begin
        w_event  = 1'b1;
        w_code   = 2'd0;
        w_pc_sel = pc_f_i;
        if (w_en_ov) begin
            w_code   = 2'd3;
            w_pc_sel = pc_m_i;
        end else if (w_en_unimpl) begin
            w_code   = 2'd2;
            w_pc_sel = pc_e_i;
        end else if (w_en_sys) begin
            w_code   = 2'd1;
            w_pc_sel = pc_d_i;
        end else if (!w_en_int) begin
            w_event  = 1'b0;
        end
    end

    assign w_int_acc = (r_state == S_IDLE) && w_event && (w_code == 2'd0);
    // A fresh edge in the accepting cycle re-arms the pending flag
    assign w_int_pending_nxt = w_int_edge | (r_int_pending & ~w_int_acc);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cew_nxt      = 1'b0;
        w_code_nxt     = exc_code_o;
        w_epc_nxt      = epc_o;
        w_ret_nxt      = 1'b0;
        w_flush_nxt    = 1'b0;
        w_redirect_nxt = 1'b0;
        w_hpc_nxt      = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = C_FLUSH_LOAD;
                    w_cew_nxt   = 1'b1;
                    w_code_nxt  = {30'd0, w_code};
                    w_epc_nxt   = w_pc_sel + 32'd4;
                    w_flush_nxt = 1'b1;
                end else if (eret_i) begin
                    w_ret_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt    = S_REDIRECT;
                    w_redirect_nxt = 1'b1;
                    w_hpc_nxt      = HANDLER_ADDR;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_flush_nxt = 1'b1;
                end
            end
            S_REDIRECT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_cnt             <= 4'd0;
            r_sync1           <= 1'b0;
            r_sync2           <= 1'b0;
            r_sync_prev       <= 1'b0;
            r_int_pending     <= 1'b0;
            cause_epc_write_o <= 1'b0;
            exc_code_o        <= 32'd0;
            epc_o             <= 32'd0;
            ret_op_o          <= 1'b0;
            flush_o           <= 1'b0;
            redirect_o        <= 1'b0;
            handler_pc_o      <= 32'd0;
        end else begin
            r_state           <= w_state_nxt;
            r_cnt             <= w_cnt_nxt;
            r_sync1           <= ext_int_i;
            r_sync2           <= r_sync1;
            r_sync_prev       <= r_sync2;
            r_int_pending     <= w_int_pending_nxt;
            cause_epc_write_o <= w_cew_nxt;
            exc_code_o        <= w_code_nxt;
            epc_o             <= w_epc_nxt;
            ret_op_o          <= w_ret_nxt;
            flush_o           <= w_flush_nxt;
            redirect_o        <= w_redirect_nxt;
            handler_pc_o      <= w_hpc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Randomised scoreboard bench for exc_ctrl with a cycle-level
//               reference model of the exception rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    localparam logic [31:0] C_HANDLER = 32'h0000_4180;
    localparam int          C_FC      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_int_i = 1'b0;
    logic        sys_i = 1'b0;
    logic        unimpl_i = 1'b0;
    logic        ov_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [31:0] pc_f_i = 32'h200;
    logic [31:0] pc_d_i = 32'h300;
    logic [31:0] pc_e_i = 32'h400;
    logic [31:0] pc_m_i = 32'h100;
    logic [31:0] status_i = 32'h0;
    logic        cause_epc_write_o;
    logic [31:0] exc_code_o;
    logic [31:0] epc_o;
    logic        ret_op_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] handler_pc_o;

    exc_ctrl #(.HANDLER_ADDR(C_HANDLER), .FLUSH_CYCLES(C_FC)) dut (
        .clk(clk), .rst(rst), .ext_int_i(ext_int_i), .sys_i(sys_i),
        .unimpl_i(unimpl_i), .ov_i(ov_i), .eret_i(eret_i),
        .pc_f_i(pc_f_i), .pc_d_i(pc_d_i), .pc_e_i(pc_e_i), .pc_m_i(pc_m_i),
        .status_i(status_i), .cause_epc_write_o(cause_epc_write_o),
        .exc_code_o(exc_code_o), .epc_o(epc_o), .ret_op_o(ret_op_o),
        .flush_o(flush_o), .redirect_o(redirect_o), .handler_pc_o(handler_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_ret;
        logic [31:0] code;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rst_at_edge = 1'b1;

    // Reference model: ext_int history, pending flag, busy window after a commit
    logic [2:0] m_hist = 3'b000;
    logic       m_pend = 1'b0;
    int         m_busy = 0;

    always @(posedge clk) begin
        logic       rise;
        logic       found;
        logic       int_acc;
        logic [1:0] code;
        logic [31:0] pc;
        rst_at_edge = rst;
        if (rst) begin
            m_hist = 3'b000;
            m_pend = 1'b0;
            m_busy = 0;
        end else begin
            rise    = m_hist[1] & ~m_hist[2];
            int_acc = 1'b0;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end else begin
                found = 1'b1;
                code  = 2'd0;
                pc    = pc_f_i;
                if (ov_i && status_i[3]) begin code = 2'd3; pc = pc_m_i; end
                else if (unimpl_i && status_i[2]) begin code = 2'd2; pc = pc_e_i; end
                else if (sys_i && status_i[1]) begin code = 2'd1; pc = pc_d_i; end
                else if (m_pend && status_i[0]) begin code = 2'd0; pc = pc_f_i; int_acc = 1'b1; end
                else found = 1'b0;
                if (found) begin
                    exp_q.push_back('{is_ret: 1'b0, code: {30'd0, code}, epc: pc + 32'd4});
                    m_busy = C_FC + 1;
                end else if (eret_i) begin
                    exp_q.push_back('{is_ret: 1'b1, code: 32'd0, epc: 32'd0});
                end
            end
            m_pend = rise | (m_pend & ~int_acc);
            m_hist = {m_hist[1:0], ext_int_i};
        end
    end

    // Monitor: pops an expectation whenever the DUT commits or returns
    int          phase = -1;
    logic [31:0] last_code = 32'd0;
    logic [31:0] last_epc = 32'd0;

    always @(negedge clk) begin
        exp_t it;
        logic exp_flush;
        logic exp_redir;
        if (rst_at_edge) begin
            checks++;
            if (cause_epc_write_o || ret_op_o || flush_o || redirect_o ||
                handler_pc_o != 0 || exc_code_o != 0 || epc_o != 0) begin
                errors++;
                $display("FAIL reset_outputs: got cew=%0b ret=%0b fl=%0b rd=%0b hpc=%h code=%h epc=%h, exp all 0",
                         cause_epc_write_o, ret_op_o, flush_o, redirect_o, handler_pc_o, exc_code_o, epc_o);
            end
            phase     = -1;
            last_code = 32'd0;
            last_epc  = 32'd0;
        end else begin
            if (cause_epc_write_o || ret_op_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got cew=%0b ret=%0b, exp none", cause_epc_write_o, ret_op_o);
                end else begin
                    it = exp_q.pop_front();
                    if (cause_epc_write_o && ret_op_o) begin
                        errors++;
                        $display("FAIL both_pulses: got cew=1 ret=1, exp one of them");
                    end else if (it.is_ret != ret_op_o) begin
                        errors++;
                        $display("FAIL kind: got ret=%0b, exp ret=%0b", ret_op_o, it.is_ret);
                    end else if (!it.is_ret && (exc_code_o != it.code || epc_o != it.epc)) begin
                        errors++;
                        $display("FAIL commit: got code=%0d epc=%h, exp code=%0d epc=%h",
                                 exc_code_o, epc_o, it.code, it.epc);
                    end
                    if (!it.is_ret) begin
                        last_code = it.code;
                        last_epc  = it.epc;
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                it = exp_q.pop_front();
                $display("FAIL missing_output: got none, exp ret=%0b code=%0d epc=%h", it.is_ret, it.code, it.epc);
            end
            if (cause_epc_write_o) phase = 0;
            else if (phase >= 0) phase++;
            if (phase > C_FC) phase = -1;
            exp_flush = (phase >= 0) && (phase < C_FC);
            exp_redir = (phase == C_FC);
            checks++;
            if (flush_o != exp_flush || redirect_o != exp_redir ||
                handler_pc_o != (exp_redir ? C_HANDLER : 32'd0) ||
                exc_code_o != last_code || epc_o != last_epc) begin
                errors++;
                $display("FAIL sequence: got fl=%0b rd=%0b hpc=%h code=%h epc=%h, exp fl=%0b rd=%0b hpc=%h code=%h epc=%h",
                         flush_o, redirect_o, handler_pc_o, exc_code_o, epc_o, exp_flush, exp_redir,
                         exp_redir ? C_HANDLER : 32'd0, last_code, last_epc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        sys_i = 0; unimpl_i = 0; ov_i = 0; eret_i = 0;
    endtask

    initial begin
        cyc(2);
        rst = 0;
        status_i = 32'hF;
        cyc(2);
        // overflow commit, flush, redirect
        ov_i = 1; pulse_clear(); cyc(6);
        // ov beats sys
        sys_i = 1; ov_i = 1; pulse_clear(); cyc(6);
        // masked interrupt stays pending until enabled
        status_i = 32'hE; ext_int_i = 1; cyc(8);
        status_i = 32'hF; cyc(6); ext_int_i = 0; cyc(4);
        // eret alone, then eret losing to unimpl
        eret_i = 1; pulse_clear(); cyc(3);
        eret_i = 1; unimpl_i = 1; pulse_clear(); cyc(6);
        // reset during flush aborts the redirect
        ov_i = 1; pulse_clear(); rst = 1; cyc(1); rst = 0; cyc(5);
        // epc wraps at 32 bits
        pc_e_i = 32'hFFFF_FFFC; unimpl_i = 1; pulse_clear(); cyc(6);
        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            sys_i    = ($urandom_range(0, 7) == 0);
            unimpl_i = ($urandom_range(0, 9) == 0);
            ov_i     = ($urandom_range(0, 11) == 0);
            eret_i   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) ext_int_i = ~ext_int_i;
            if ($urandom_range(0, 15) == 0) status_i = {28'd0, 4'($urandom)};
            pc_f_i = $urandom; pc_d_i = $urandom; pc_e_i = $urandom; pc_m_i = $urandom;
            if ($urandom_range(0, 5) == 0) pc_m_i = 32'hFFFF_FFFC;
            rst = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        rst = 0; sys_i = 0; unimpl_i = 0; ov_i = 0; eret_i = 0; ext_int_i = 0;
        status_i = 32'h0;
        cyc(12);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding, exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
